// File: rtl/ov7670_capture.sv
// OV7670 capture front end: synchronises the camera bus into Clk_i, packs RGB565
// byte pairs into 16-bit pixels ({byte2, byte1}) and strobes them to the frame buffer.
module ov7670_capture #(
  parameter int H_PIXELS    = 640,
  parameter int V_LINES     = 480,
  parameter int SYNC_STAGES = 2
) (
  input  logic        Clk_i,
  input  logic        Reset_i,
  input  logic        Enable_i,
  input  logic        Cam_Pclk_i,
  input  logic        Cam_Vsync_i,
  input  logic        Cam_Href_i,
  input  logic [7:0]  Cam_Data_i,
  input  logic        Full_i,
  output logic [15:0] Pixel_o,
  output logic        Write_En_o,
  output logic        Frame_Start_o,
  output logic        Frame_Done_o,
  output logic [9:0]  Line_Count_o,
  output logic        Overflow_o,
  output logic        Size_Err_o,
  output logic [1:0]  State_o
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT_VS = 2'd1,
    CAPTURE = 2'd2,
    DONE    = 2'd3
  } state_t;

  localparam logic [9:0] H_MAX   = 10'(H_PIXELS);
  localparam logic [9:0] V_MAX   = 10'(V_LINES);
  localparam logic [9:0] CNT_SAT = 10'h3FF;

  // All camera signals share one chain so data stays aligned with its PCLK edge.
  logic [10:0] sync_q [SYNC_STAGES];
  logic [10:0] sync_out;
  logic        s_pclk, s_vsync, s_href;
  logic [7:0]  s_data;
  logic        pclk_d, vsync_d, href_d;
  logic        pclk_rise, vs_rise, vs_fall, href_fall;

  always_ff @(posedge Clk_i or negedge Reset_i) begin
    if (!Reset_i) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
      pclk_d  <= 1'b0;
      vsync_d <= 1'b0;
      href_d  <= 1'b0;
    end else begin
      sync_q[0] <= {Cam_Pclk_i, Cam_Vsync_i, Cam_Href_i, Cam_Data_i};
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      pclk_d  <= s_pclk;
      vsync_d <= s_vsync;
      href_d  <= s_href;
    end
  end

  assign sync_out  = sync_q[SYNC_STAGES-1];
  assign s_pclk    = sync_out[10];
  assign s_vsync   = sync_out[9];
  assign s_href    = sync_out[8];
  assign s_data    = sync_out[7:0];
  assign pclk_rise = s_pclk & ~pclk_d;
  assign vs_rise   = s_vsync & ~vsync_d;
  assign vs_fall   = ~s_vsync & vsync_d;
  assign href_fall = ~s_href & href_d;

  state_t      state;
  logic        phase;
  logic [7:0]  byte1;
  logic [9:0]  pixel_count;
  logic        geom_bad;

  always_ff @(posedge Clk_i or negedge Reset_i) begin
    if (!Reset_i) begin
      state         <= IDLE;
      phase         <= 1'b0;
      byte1         <= '0;
      pixel_count   <= '0;
      geom_bad      <= 1'b0;
      Pixel_o       <= '0;
      Write_En_o    <= 1'b0;
      Frame_Start_o <= 1'b0;
      Frame_Done_o  <= 1'b0;
      Line_Count_o  <= '0;
      Overflow_o    <= 1'b0;
      Size_Err_o    <= 1'b0;
    end else begin
      Write_En_o    <= 1'b0;
      Frame_Start_o <= 1'b0;
      Frame_Done_o  <= 1'b0;
      case (state)
        IDLE: begin
          if (Enable_i) state <= WAIT_VS;
        end
        WAIT_VS: begin
          if (!Enable_i) begin
            state <= IDLE;
          end else if (vs_fall) begin
            Frame_Start_o <= 1'b1;
            pixel_count   <= '0;
            Line_Count_o  <= '0;
            phase         <= 1'b0;
            geom_bad      <= 1'b0;
            Overflow_o    <= 1'b0;
            Size_Err_o    <= 1'b0;
            state         <= CAPTURE;
          end
        end
        CAPTURE: begin
          if (!Enable_i) begin
            state <= IDLE;
          end else begin
            if (href_fall) begin
              // Any odd trailing byte is simply forgotten by clearing phase.
              if (Line_Count_o != CNT_SAT) Line_Count_o <= Line_Count_o + 10'd1;
              if (pixel_count != H_MAX) geom_bad <= 1'b1;
              pixel_count <= '0;
              phase       <= 1'b0;
            end else if (pclk_rise && s_href) begin
              if (!phase) begin
                byte1 <= s_data;
                phase <= 1'b1;
              end else begin
                phase <= 1'b0;
                if (pixel_count != CNT_SAT) pixel_count <= pixel_count + 10'd1;
                if (pixel_count < H_MAX && Line_Count_o < V_MAX) begin
                  if (Full_i) begin
                    Overflow_o <= 1'b1;
                  end else begin
                    Write_En_o <= 1'b1;
                    Pixel_o    <= {s_data, byte1};
                  end
                end
              end
            end
            if (vs_rise) begin
              Frame_Done_o <= 1'b1;
              state        <= DONE;
            end
          end
        end
        DONE: begin
          if (Line_Count_o != V_MAX || geom_bad) Size_Err_o <= 1'b1;
          state <= Enable_i ? WAIT_VS : IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign State_o = state;

endmodule

// File: tb/tb_ov7670_capture.sv
// Directed bench for ov7670_capture with a 4x2 frame geometry and a slow camera model.
module tb_ov7670_capture;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        enable;
  logic        cam_pclk, cam_vsync, cam_href;
  logic [7:0]  cam_data;
  logic        full;
  logic [15:0] pixel;
  logic        write_en, frame_start, frame_done, overflow, size_err;
  logic [9:0]  line_count;
  logic [1:0]  state_dbg;

  int checks = 0;
  int failures = 0;

  logic [15:0] obs_q[$];
  logic [15:0] exp_q[$];
  int wr_count = 0;
  int fs_count = 0;
  int fd_count = 0;

  always #5 clk = ~clk;

  ov7670_capture #(.H_PIXELS(4), .V_LINES(2), .SYNC_STAGES(2)) dut (
    .Clk_i(clk), .Reset_i(rst_n), .Enable_i(enable),
    .Cam_Pclk_i(cam_pclk), .Cam_Vsync_i(cam_vsync), .Cam_Href_i(cam_href),
    .Cam_Data_i(cam_data), .Full_i(full),
    .Pixel_o(pixel), .Write_En_o(write_en), .Frame_Start_o(frame_start),
    .Frame_Done_o(frame_done), .Line_Count_o(line_count), .Overflow_o(overflow),
    .Size_Err_o(size_err), .State_o(state_dbg)
  );

  // Output monitor: records every write and frame pulse.
  always @(negedge clk) begin
    if (write_en) begin
      obs_q.push_back(pixel);
      wr_count++;
    end
    if (frame_start) fs_count++;
    if (frame_done) fd_count++;
  end

  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic cam_byte(input logic [7:0] b);
    cam_data = b;
    cam_pclk = 1'b0;
    wait_clks(4);
    cam_pclk = 1'b1;
    wait_clks(4);
  endtask

  task automatic cam_line(input int nbytes, input logic [7:0] first);
    cam_href = 1'b1;
    for (int i = 0; i < nbytes; i++) cam_byte(8'(int'(first) + i));
    cam_pclk = 1'b0;
    wait_clks(4);
    cam_href = 1'b0;
    wait_clks(12);
  endtask

  task automatic frame_begin();
    cam_vsync = 1'b1;
    wait_clks(10);
    cam_vsync = 1'b0;
    wait_clks(10);
  endtask

  task automatic frame_end();
    cam_vsync = 1'b1;
    wait_clks(10);
  endtask

  task automatic test_reset();
    wait_clks(2);
    checks++; if (pixel !== 16'h0) begin failures++; $display("FAIL reset_pixel got=%h exp=0000", pixel); end
    checks++; if (write_en !== 1'b0) begin failures++; $display("FAIL reset_write_en got=%b exp=0", write_en); end
    checks++; if (frame_start !== 1'b0 || frame_done !== 1'b0) begin failures++; $display("FAIL reset_frame_pulses got=%b%b exp=00", frame_start, frame_done); end
    checks++; if (line_count !== 10'd0) begin failures++; $display("FAIL reset_line_count got=%0d exp=0", line_count); end
    checks++; if (overflow !== 1'b0 || size_err !== 1'b0) begin failures++; $display("FAIL reset_flags got=%b%b exp=00", overflow, size_err); end
    checks++; if (state_dbg !== 2'd0) begin failures++; $display("FAIL reset_state got=%0d exp=0", state_dbg); end
  endtask

  task automatic test_nominal();
    int base, wr0, fs0, fd0;
    base = obs_q.size(); wr0 = wr_count; fs0 = fs_count; fd0 = fd_count;
    exp_q = '{16'h0201, 16'h0403, 16'h0605, 16'h0807, 16'h0A09, 16'h0C0B, 16'h0E0D, 16'h100F};
    enable = 1'b1;
    wait_clks(3);
    frame_begin();
    cam_line(8, 8'h01);
    cam_line(8, 8'h09);
    frame_end();
    checks++; if (wr_count - wr0 !== 8) begin failures++; $display("FAIL nominal_writes got=%0d exp=8", wr_count - wr0); end
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if (base + i >= obs_q.size()) begin failures++; $display("FAIL nominal_pixel%0d got=none exp=%h", i, exp_q[i]); end
      else if (obs_q[base+i] !== exp_q[i]) begin failures++; $display("FAIL nominal_pixel%0d got=%h exp=%h", i, obs_q[base+i], exp_q[i]); end
    end
    checks++; if (fs_count - fs0 !== 1 || fd_count - fd0 !== 1) begin failures++; $display("FAIL nominal_frame_pulses got=%0d/%0d exp=1/1", fs_count - fs0, fd_count - fd0); end
    checks++; if (line_count !== 10'd2) begin failures++; $display("FAIL nominal_line_count got=%0d exp=2", line_count); end
    checks++; if (size_err !== 1'b0) begin failures++; $display("FAIL nominal_size_err got=%b exp=0", size_err); end
    checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL nominal_overflow got=%b exp=0", overflow); end
  endtask

  task automatic test_midframe_enable();
    int base, wr0;
    enable = 1'b0;
    wait_clks(3);
    cam_vsync = 1'b0;
    wait_clks(10);
    cam_line(8, 8'hC1);
    enable = 1'b1;
    wait_clks(3);
    wr0 = wr_count;
    cam_line(8, 8'hD1);
    frame_end();
    checks++; if (wr_count - wr0 !== 0) begin failures++; $display("FAIL midframe_no_writes got=%0d exp=0", wr_count - wr0); end
    base = obs_q.size(); wr0 = wr_count;
    frame_begin();
    cam_line(8, 8'h21);
    cam_line(8, 8'h29);
    frame_end();
    checks++; if (wr_count - wr0 !== 8) begin failures++; $display("FAIL midframe_writes got=%0d exp=8", wr_count - wr0); end
    checks++;
    if (base >= obs_q.size()) begin failures++; $display("FAIL midframe_first_pixel got=none exp=2221"); end
    else if (obs_q[base] !== 16'h2221) begin failures++; $display("FAIL midframe_first_pixel got=%h exp=2221", obs_q[base]); end
    checks++; if (pixel !== 16'h302F) begin failures++; $display("FAIL midframe_last_pixel got=%h exp=302f", pixel); end
  endtask

  task automatic test_full();
    int base, wr0;
    base = obs_q.size(); wr0 = wr_count;
    exp_q = '{16'h4241, 16'h4443, 16'h4847, 16'h4A49, 16'h4C4B, 16'h4E4D, 16'h504F};
    frame_begin();
    cam_href = 1'b1;
    for (int i = 0; i < 8; i++) begin
      full = (i == 5);
      cam_byte(8'(8'h41 + i));
    end
    full = 1'b0;
    cam_pclk = 1'b0;
    wait_clks(4);
    cam_href = 1'b0;
    wait_clks(12);
    cam_line(8, 8'h49);
    frame_end();
    checks++; if (wr_count - wr0 !== 7) begin failures++; $display("FAIL full_writes got=%0d exp=7", wr_count - wr0); end
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if (base + i >= obs_q.size()) begin failures++; $display("FAIL full_pixel%0d got=none exp=%h", i, exp_q[i]); end
      else if (obs_q[base+i] !== exp_q[i]) begin failures++; $display("FAIL full_pixel%0d got=%h exp=%h", i, obs_q[base+i], exp_q[i]); end
    end
    checks++; if (overflow !== 1'b1) begin failures++; $display("FAIL full_overflow got=%b exp=1", overflow); end
    checks++; if (size_err !== 1'b0) begin failures++; $display("FAIL full_size_err got=%b exp=0", size_err); end
  endtask

  task automatic test_geometry();
    int base, wr0;
    base = obs_q.size(); wr0 = wr_count;
    exp_q = '{16'h6261, 16'h6463, 16'h6665, 16'h6867, 16'h7271};
    frame_begin();
    checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL overflow_cleared got=%b exp=0", overflow); end
    cam_line(10, 8'h61);
    cam_line(3, 8'h71);
    frame_end();
    checks++; if (wr_count - wr0 !== 5) begin failures++; $display("FAIL geom_writes got=%0d exp=5", wr_count - wr0); end
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if (base + i >= obs_q.size()) begin failures++; $display("FAIL geom_pixel%0d got=none exp=%h", i, exp_q[i]); end
      else if (obs_q[base+i] !== exp_q[i]) begin failures++; $display("FAIL geom_pixel%0d got=%h exp=%h", i, obs_q[base+i], exp_q[i]); end
    end
    checks++; if (size_err !== 1'b1) begin failures++; $display("FAIL geom_size_err got=%b exp=1", size_err); end
    checks++; if (line_count !== 10'd2) begin failures++; $display("FAIL geom_line_count got=%0d exp=2", line_count); end
  endtask

  task automatic test_abort();
    int wr0, fd0;
    wr0 = wr_count; fd0 = fd_count;
    frame_begin();
    cam_href = 1'b1;
    for (int i = 0; i < 6; i++) cam_byte(8'(8'h81 + i));
    enable = 1'b0;
    wait_clks(2);
    checks++; if (state_dbg !== 2'd0) begin failures++; $display("FAIL abort_state got=%0d exp=0", state_dbg); end
    cam_byte(8'h87);
    cam_byte(8'h88);
    cam_pclk = 1'b0;
    wait_clks(4);
    cam_href = 1'b0;
    wait_clks(12);
    frame_end();
    checks++; if (wr_count - wr0 !== 3) begin failures++; $display("FAIL abort_writes got=%0d exp=3", wr_count - wr0); end
    checks++; if (fd_count - fd0 !== 0) begin failures++; $display("FAIL abort_frame_done got=%0d exp=0", fd_count - fd0); end
    checks++; if (pixel !== 16'h8685) begin failures++; $display("FAIL abort_pixel_hold got=%h exp=8685", pixel); end
  endtask

  task automatic test_reset_midline();
    int base, wr0, fs0;
    enable = 1'b1;
    wait_clks(3);
    frame_begin();
    cam_line(8, 8'h91);
    cam_href = 1'b1;
    cam_byte(8'h99);
    cam_byte(8'h9A);
    rst_n = 1'b0;
    #2;
    checks++; if (pixel !== 16'h0 || write_en !== 1'b0) begin failures++; $display("FAIL rst_mid_pixel got=%h/%b exp=0000/0", pixel, write_en); end
    checks++; if (line_count !== 10'd0) begin failures++; $display("FAIL rst_mid_line_count got=%0d exp=0", line_count); end
    checks++; if (state_dbg !== 2'd0) begin failures++; $display("FAIL rst_mid_state got=%0d exp=0", state_dbg); end
    wait_clks(1);
    rst_n = 1'b1;
    wr0 = wr_count;
    cam_byte(8'h9B);
    cam_byte(8'h9C);
    cam_pclk = 1'b0;
    wait_clks(4);
    cam_href = 1'b0;
    wait_clks(12);
    cam_line(8, 8'hA1);
    frame_end();
    checks++; if (wr_count - wr0 !== 0) begin failures++; $display("FAIL rst_mid_no_writes got=%0d exp=0", wr_count - wr0); end
    base = obs_q.size(); wr0 = wr_count; fs0 = fs_count;
    frame_begin();
    checks++; if (fs_count - fs0 !== 1) begin failures++; $display("FAIL rst_mid_frame_start got=%0d exp=1", fs_count - fs0); end
    cam_line(8, 8'hB1);
    cam_line(8, 8'hB9);
    frame_end();
    checks++; if (wr_count - wr0 !== 8) begin failures++; $display("FAIL rst_mid_writes got=%0d exp=8", wr_count - wr0); end
    checks++;
    if (base >= obs_q.size()) begin failures++; $display("FAIL rst_mid_first_pixel got=none exp=b2b1"); end
    else if (obs_q[base] !== 16'hB2B1) begin failures++; $display("FAIL rst_mid_first_pixel got=%h exp=b2b1", obs_q[base]); end
    checks++; if (line_count !== 10'd2) begin failures++; $display("FAIL rst_mid_line_count2 got=%0d exp=2", line_count); end
  endtask

  initial begin
    rst_n = 1'b0;
    enable = 1'b0;
    cam_pclk = 1'b0;
    cam_vsync = 1'b0;
    cam_href = 1'b0;
    cam_data = 8'h00;
    full = 1'b0;
    wait_clks(3);
    rst_n = 1'b1;
    test_reset();
    test_nominal();
    test_midframe_enable();
    test_full();
    test_geometry();
    test_abort();
    test_reset_midline();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
